// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: EX forwarding, load-use/branch hazards, multi-cycle divide hold (HAZARD_PERF_CNT_EN adds perf counters).
// Latency: forwarding/hazard outputs are combinational; divide occupies EX for DIV_LATENCY cycles via a registered FSM.
// Backpressure: stalls upstream through pc_write_en/if_id_write_en and holds EX with ex_hold while the divider runs.
module hazard_stall_controller #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_is_div,
    input  logic       ex_branch_taken,
    input  logic [4:0] ma_rd,
    input  logic       ma_regwrite,
    input  logic       ma_mem_read,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic       pc_write_en,
    output logic       if_id_write_en,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_hold,
    output logic       ex_ma_bubble,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       div_start,
    output logic       div_busy,
    output logic       div_result_valid
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    // A load sitting in MA has no data yet, so only non-load MA results are forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic       m_ld,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && !m_ld && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b01;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_is_div) begin
                    cnt_d   = CNT_W'(DIV_LATENCY - 2);
                    state_d = (DIV_LATENCY == 2) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_write_en      = 1'b1;
        if_id_write_en   = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;
        ex_hold          = 1'b0;
        ex_ma_bubble     = 1'b0;
        fwd_a_sel        = fwd_sel(ex_rs1, ma_rd, ma_regwrite, ma_mem_read, wb_rd, wb_regwrite);
        fwd_b_sel        = fwd_sel(ex_rs2, ma_rd, ma_regwrite, ma_mem_read, wb_rd, wb_regwrite);
        div_start        = 1'b0;
        div_busy         = 1'b0;
        div_result_valid = 1'b0;
        if (RESET) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            ex_ma_bubble   = 1'b1;
            fwd_a_sel      = 2'b00;
            fwd_b_sel      = 2'b00;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_is_div) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        ex_hold        = 1'b1;
                        ex_ma_bubble   = 1'b1;
                        div_start      = 1'b1;
                        div_busy       = 1'b1;
                    end else if (ex_branch_taken) begin
                        // The ID instruction is squashed, so any load-use match is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                    end
                end
                ST_BUSY: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    ex_hold        = 1'b1;
                    ex_ma_bubble   = 1'b1;
                    div_busy       = 1'b1;
                end
                ST_DONE: begin
                    div_result_valid = 1'b1;
                    if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                    end
                end
                default: begin
                    pc_write_en = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_en && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF))
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (DIV_LATENCY 32 and 2) checked against a cycle scoreboard.
module tb_hazard_stall_controller;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       flush;
        logic       idb;
        logic       hold;
        logic       exmab;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       start;
        logic       busy;
        logic       valid;
    } ctl_t;

    logic       CLK;
    logic       RESET;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ma_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_is_div, ex_branch_taken;
    logic       ma_regwrite, ma_mem_read, wb_regwrite;

    logic       pc0, ifid0, fl0, idb0, hold0, exmab0, st0, busy0, val0;
    logic [1:0] fa0, fb0;
    logic       pc1, ifid1, fl1, idb1, hold1, exmab1, st1, busy1, val1;
    logic [1:0] fa1, fb1;
    ctl_t       got0, got1;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int k0 = -1;
    int k1 = -1;
    ctl_t q0[$];
    ctl_t q1[$];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [31:0] exp_sc0 = 0, exp_fc0 = 0, exp_sc1 = 0, exp_fc1 = 0;
`endif

    hazard_stall_controller u_dut (
        .CLK(CLK), .RESET(RESET),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .ma_rd(ma_rd), .ma_regwrite(ma_regwrite), .ma_mem_read(ma_mem_read),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write_en(pc0), .if_id_write_en(ifid0), .if_id_flush(fl0), .id_ex_bubble(idb0),
        .ex_hold(hold0), .ex_ma_bubble(exmab0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
        .div_start(st0), .div_busy(busy0), .div_result_valid(val0)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc0), .flush_count(fc0)
`endif
    );

    hazard_stall_controller #(.DIV_LATENCY(2), .CNT_W(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .ma_rd(ma_rd), .ma_regwrite(ma_regwrite), .ma_mem_read(ma_mem_read),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_write_en(pc1), .if_id_write_en(ifid1), .if_id_flush(fl1), .id_ex_bubble(idb1),
        .ex_hold(hold1), .ex_ma_bubble(exmab1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .div_start(st1), .div_busy(busy1), .div_result_valid(val1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .flush_count(fc1)
`endif
    );

    assign got0 = {pc0, ifid0, fl0, idb0, hold0, exmab0, fa0, fb0, st0, busy0, val0};
    assign got1 = {pc1, ifid1, fl1, idb1, hold1, exmab1, fa1, fb1, st1, busy1, val1};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (ma_regwrite && !ma_mem_read && ma_rd == rs) return 2'b01;
        if (wb_regwrite && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // k is the position of the divide within its EX residency (-1 when none).
    task automatic predict(input int lat, input int k, output ctl_t e, output int kn);
        logic lu;
        e  = '0;
        kn = k;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (RESET) begin
            e.flush = 1'b1; e.idb = 1'b1; e.exmab = 1'b1;
            kn = -1;
        end else begin
            e.pc_we = 1'b1; e.ifid_we = 1'b1;
            e.fa = fwd_ref(ex_rs1);
            e.fb = fwd_ref(ex_rs2);
            if (kn < 0 && ex_is_div) kn = 0;
            if (kn >= 0 && kn < lat - 1) begin
                e.pc_we = 1'b0; e.ifid_we = 1'b0; e.hold = 1'b1; e.exmab = 1'b1;
                e.busy = 1'b1; e.start = (kn == 0);
                kn = kn + 1;
            end else if (kn >= 0) begin
                e.valid = 1'b1;
                if (lu) begin e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idb = 1'b1; end
                kn = -1;
            end else if (ex_branch_taken) begin
                e.flush = 1'b1; e.idb = 1'b1;
            end else if (lu) begin
                e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idb = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        ctl_t e0, e1, x;
        int n0, n1;
        predict(32, k0, e0, n0);
        predict(2, k1, e1, n1);
        q0.push_back(e0);
        q1.push_back(e1);
        k0 = n0;
        k1 = n1;
        @(negedge CLK);
        x = q0.pop_front();
        check_eq("ctl_lat32", 32'(got0), 32'(x));
        x = q1.pop_front();
        check_eq("ctl_lat2", 32'(got1), 32'(x));
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cycles_lat32", sc0, exp_sc0);
        check_eq("flush_count_lat32", fc0, exp_fc0);
        check_eq("stall_cycles_lat2", sc1, exp_sc1);
        check_eq("flush_count_lat2", fc1, exp_fc1);
        if (RESET) begin
            exp_sc0 = 0; exp_fc0 = 0; exp_sc1 = 0; exp_fc1 = 0;
        end else begin
            exp_sc0 += 32'(!e0.pc_we); exp_fc0 += 32'(e0.flush);
            exp_sc1 += 32'(!e1.pc_we); exp_fc1 += 32'(e1.flush);
        end
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_is_div = 0; ex_branch_taken = 0;
        ma_rd = 0; ma_regwrite = 0; ma_mem_read = 0; wb_rd = 0; wb_regwrite = 0;
    endtask

    initial begin
        clr();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        cyc();
        cyc();
        RESET = 1'b0;
        cyc();

        // lw x5,0(x1) in EX, add x6,x5,x2 in ID
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
        cyc();
        ex_mem_read = 0; ex_rd = 0; ma_rd = 5; ma_regwrite = 1; ma_mem_read = 1;
        cyc();
        clr();
        ex_rs1 = 5; ex_rs2 = 2; ex_rd = 6; wb_rd = 5; wb_regwrite = 1;
        cyc();

        // forwarding priority, MA load exclusion, x0 guard
        clr();
        ma_rd = 7; wb_rd = 7; ma_regwrite = 1; wb_regwrite = 1; ex_rs2 = 7;
        cyc();
        ma_rd = 0;
        cyc();
        ma_rd = 7; ma_mem_read = 1; ex_rs1 = 7;
        cyc();
        clr();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; ma_rd = 0; ma_regwrite = 1;
        cyc();

        // rs2 hazard only when rs2 is in use, then branch overriding load-use
        clr();
        ex_mem_read = 1; ex_rd = 3; id_rs2 = 3;
        cyc();
        id_use_rs2 = 1;
        cyc();
        ex_branch_taken = 1;
        cyc();

        // long divide with branches ignored while busy; lat-2 instance runs back-to-back
        clr();
        ex_is_div = 1;
        for (int i = 0; i < 32; i++) begin
            ex_branch_taken = (i % 5 == 3);
            cyc();
        end
        clr();
        cyc();
        cyc();

        // reset aborts the divide part-way through BUSY
        ex_is_div = 1;
        for (int i = 0; i < 21; i++) cyc();
        RESET = 1'b1; ex_is_div = 0;
        cyc();
        RESET = 1'b0;
        cyc();
        cyc();

        for (int i = 0; i < 400; i++) begin
            RESET           = ($urandom_range(0, 59) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_rs1          = 5'($urandom_range(0, 3));
            ex_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_is_div       = ($urandom_range(0, 9) == 0);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ma_rd           = 5'($urandom_range(0, 3));
            ma_regwrite     = 1'($urandom_range(0, 1));
            ma_mem_read     = 1'($urandom_range(0, 1));
            wb_rd           = 5'($urandom_range(0, 3));
            wb_regwrite     = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
